// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus scheduler.
// Holds the FSM state encoding, requester indices and default phase timing.
package rtc_bus_pkg;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned REQ_IDX_W = 2;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CNT_W     = 8;

    localparam logic [REQ_IDX_W-1:0] REQ_INIT  = 2'd0;
    localparam logic [REQ_IDX_W-1:0] REQ_WRITE = 2'd1;
    localparam logic [REQ_IDX_W-1:0] REQ_CRONO = 2'd2;
    localparam logic [REQ_IDX_W-1:0] REQ_READ  = 2'd3;

    localparam int unsigned T_SETUP_DEF  = 2;
    localparam int unsigned T_STROBE_DEF = 5;
    localparam int unsigned T_HOLD_DEF   = 2;
    localparam int unsigned T_GAP_DEF    = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_GAP,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD,
        ST_RECOV
    } state_t;

    // Next round-robin candidate among requesters 1..3.
    function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] idx);
        return (idx == REQ_READ || idx == REQ_INIT) ? REQ_WRITE : idx + REQ_IDX_W'(1);
    endfunction

endpackage

// File: rtl/rtc_rr_arbiter.sv
// Combinational requester select: init has absolute priority,
// the other three rotate starting after the pointer.
module rtc_rr_arbiter
    import rtc_bus_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]   winner,
    output logic [REQ_IDX_W-1:0] winner_idx
);

    logic [REQ_IDX_W-1:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        cand       = ptr;
        if (req[REQ_INIT]) begin
            winner[REQ_INIT] = 1'b1;
            winner_idx       = REQ_INIT;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cand = rr_next(cand);
                if (req[cand] && winner == '0) begin
                    winner[cand] = 1'b1;
                    winner_idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates four requesters onto the RTC multiplexed address/data bus and
// runs the full address-phase / data-phase bus cycle for the winner.
module rtc_bus_scheduler
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SETUP  = T_SETUP_DEF,
    parameter int unsigned T_STROBE = T_STROBE_DEF,
    parameter int unsigned T_HOLD   = T_HOLD_DEF,
    parameter int unsigned T_GAP    = T_GAP_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   rnw_in,
    input  logic [31:0]          addr_in,
    input  logic [31:0]          wdata_in,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 done,
    output logic [BYTE_W-1:0]    rdata,
    input  logic [BYTE_W-1:0]    bus_in,
    output logic [BYTE_W-1:0]    bus_out,
    output logic                 bus_oe,
    output logic                 cs_n,
    output logic                 rd_n,
    output logic                 wr_n,
    output logic                 ad
);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [REQ_IDX_W-1:0] ptr;
    logic [NUM_REQ-1:0]   win;
    logic [REQ_IDX_W-1:0] win_idx;
    logic [BYTE_W-1:0]    cap_addr, cap_wdata;
    logic                 cap_rnw;
    logic                 start, last;
    logic [BYTE_W-1:0]    sel_addr, sel_wdata, tx_addr, tx_wdata;
    logic                 tx_rnw;

    logic [NUM_REQ-1:0]   grant_nxt;
    logic                 busy_nxt, done_nxt, bus_oe_nxt, cs_n_nxt, rd_n_nxt, wr_n_nxt, ad_nxt;
    logic [BYTE_W-1:0]    rdata_nxt, bus_out_nxt;

    rtc_rr_arbiter u_arb (
        .req        (req),
        .ptr        (ptr),
        .winner     (win),
        .winner_idx (win_idx)
    );

    assign start     = (state == ST_IDLE) && (req != '0);
    assign last      = (cnt == '0);
    assign sel_addr  = addr_in[{win_idx, 3'b000} +: BYTE_W];
    assign sel_wdata = wdata_in[{win_idx, 3'b000} +: BYTE_W];
    assign tx_addr   = start ? sel_addr  : cap_addr;
    assign tx_wdata  = start ? sel_wdata : cap_wdata;
    assign tx_rnw    = start ? rnw_in[win_idx] : cap_rnw;

    // Address setup is loaded one longer: its first cycle is the capture cycle.
    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            ST_A_SETUP:              return CNT_W'(T_SETUP);
            ST_D_SETUP:              return CNT_W'(T_SETUP - 1);
            ST_A_STROBE, ST_D_STROBE: return CNT_W'(T_STROBE - 1);
            ST_A_HOLD, ST_D_HOLD:    return CNT_W'(T_HOLD - 1);
            ST_GAP, ST_RECOV:        return CNT_W'(T_GAP - 1);
            default:                 return '0;
        endcase
    endfunction

    // State, phase counter, pointer and transaction capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ptr       <= REQ_READ;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_rnw   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                cap_addr  <= sel_addr;
                cap_wdata <= sel_wdata;
                cap_rnw   <= rnw_in[win_idx];
                if (win_idx != REQ_INIT) ptr <= win_idx;
            end
        end
    end

    // Next-state and phase counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = last ? cnt : cnt - CNT_W'(1);
        case (state)
            ST_IDLE:     if (req != '0) state_nxt = ST_A_SETUP;
            ST_A_SETUP:  if (last) state_nxt = ST_A_STROBE;
            ST_A_STROBE: if (last) state_nxt = ST_A_HOLD;
            ST_A_HOLD:   if (last) state_nxt = ST_GAP;
            ST_GAP:      if (last) state_nxt = ST_D_SETUP;
            ST_D_SETUP:  if (last) state_nxt = ST_D_STROBE;
            ST_D_STROBE: if (last) state_nxt = ST_D_HOLD;
            ST_D_HOLD:   if (last) state_nxt = ST_RECOV;
            ST_RECOV:    if (last) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = phase_len(state_nxt);
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        grant_nxt   = grant;
        busy_nxt    = (state_nxt != ST_IDLE);
        done_nxt    = (state_nxt == ST_RECOV) && (state != ST_RECOV);
        rdata_nxt   = rdata;
        bus_out_nxt = bus_out;
        bus_oe_nxt  = 1'b0;
        cs_n_nxt    = 1'b1;
        rd_n_nxt    = 1'b1;
        wr_n_nxt    = 1'b1;
        ad_nxt      = 1'b1;
        if (start) grant_nxt = win;
        if (state_nxt == ST_RECOV || state_nxt == ST_IDLE) grant_nxt = '0;
        if (state == ST_D_STROBE && last && cap_rnw) rdata_nxt = bus_in;
        case (state_nxt)
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                cs_n_nxt    = 1'b0;
                ad_nxt      = 1'b0;
                bus_oe_nxt  = 1'b1;
                bus_out_nxt = tx_addr;
                if (state_nxt == ST_A_STROBE) wr_n_nxt = 1'b0;
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                cs_n_nxt   = 1'b0;
                bus_oe_nxt = !tx_rnw;
                if (!tx_rnw) bus_out_nxt = tx_wdata;
                if (state_nxt == ST_D_STROBE) begin
                    rd_n_nxt = !tx_rnw;
                    wr_n_nxt = tx_rnw;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            bus_out <= '0;
            bus_oe  <= 1'b0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            ad      <= 1'b1;
        end else begin
            grant   <= grant_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            rdata   <= rdata_nxt;
            bus_out <= bus_out_nxt;
            bus_oe  <= bus_oe_nxt;
            cs_n    <= cs_n_nxt;
            rd_n    <= rd_n_nxt;
            wr_n    <= wr_n_nxt;
            ad      <= ad_nxt;
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench for rtc_bus_scheduler: directed vector table, corner
// sequences and random traffic against a transaction-offset reference model.
module tb_rtc_bus_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, rnw_in;
    logic [31:0] addr_in, wdata_in;
    logic [3:0]  grant;
    logic        busy, done;
    logic [7:0]  rdata, bus_in, bus_out;
    logic        bus_oe, cs_n, rd_n, wr_n, ad;

    always #5 clk = ~clk;

    rtc_bus_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .rnw_in(rnw_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .grant(grant), .busy(busy),
        .done(done), .rdata(rdata), .bus_in(bus_in), .bus_out(bus_out),
        .bus_oe(bus_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad(ad)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a transaction is an offset t from the grant cycle.
    // Offsets: addr setup 0-2, addr strobe 3-7, addr hold 8-9, gap 10-13,
    // data setup 14-15, data strobe 16-20, data hold 21-22, recovery 23-26.
    bit         m_busy;
    int         m_t, m_idx, m_ptr;
    bit         m_rnw;
    logic [7:0] m_addr, m_wdata, m_rdata;

    typedef struct {
        logic [3:0] req;
        logic [3:0] rnw;
        logic [7:0] bus_in;
        logic [3:0] exp_grant;
        logic [7:0] exp_abus;
        logic [7:0] exp_dbus;
        logic [7:0] exp_rdata;
        int         exp_wr_lo;
        int         exp_rd_lo;
    } vec_t;

    vec_t       vecs[7];
    logic [3:0] gq[$];
    int         nd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_t     = 0;
        m_idx   = 0;
        m_ptr   = 3;
        m_rdata = 8'h00;
    endtask

    task automatic model_edge();
        int c;
        bit found;
        if (m_busy) begin
            if (m_t == 20 && m_rnw) m_rdata = bus_in;
            m_t++;
            if (m_t >= 27) m_busy = 1'b0;
        end else if (req != 4'b0000) begin
            if (req[0]) m_idx = 0;
            else begin
                c = m_ptr;
                found = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    c = (c % 3) + 1;
                    if (!found && req[c]) begin
                        m_idx = c;
                        found = 1'b1;
                    end
                end
                m_ptr = m_idx;
            end
            m_busy  = 1'b1;
            m_t     = 0;
            m_rnw   = rnw_in[m_idx];
            m_addr  = addr_in[m_idx*8 +: 8];
            m_wdata = wdata_in[m_idx*8 +: 8];
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        logic ecs, ead, ewr, erd, eoe, edone, ebusy;
        int t;
        t = m_t;
        if (m_busy) begin
            eg    = (t < 23) ? (4'b0001 << m_idx) : 4'b0000;
            ebusy = 1'b1;
            edone = (t == 23);
            ecs   = !((t < 10) || (t >= 14 && t < 23));
            ead   = (t >= 10);
            ewr   = !((t >= 3 && t < 8) || (!m_rnw && t >= 16 && t < 21));
            erd   = !(m_rnw && t >= 16 && t < 21);
            eoe   = (t < 10) || (!m_rnw && t >= 14 && t < 23);
        end else begin
            eg = 4'b0000; ebusy = 0; edone = 0; ecs = 1; ead = 1; ewr = 1; erd = 1; eoe = 0;
        end
        check("grant", grant, eg);
        check("busy", busy, ebusy);
        check("done", done, edone);
        check("cs_n", cs_n, ecs);
        check("ad", ad, ead);
        check("wr_n", wr_n, ewr);
        check("rd_n", rd_n, erd);
        check("bus_oe", bus_oe, eoe);
        check("rdata", rdata, m_rdata);
        if (eoe) check("bus_out", bus_out, (t < 10) ? m_addr : m_wdata);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int cyc, wr_lo, rd_lo, done_at, ndone;
        logic [7:0] abus, dbus;
        bit got;
        rnw_in = v.rnw; req = v.req; bus_in = v.bus_in;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            if (grant != 4'b0000) got = 1'b1;
        end
        check($sformatf("vec%0d_grant", n), grant, v.exp_grant);
        req = 4'b0000;
        cyc = 0; wr_lo = 0; rd_lo = 0; done_at = -1; ndone = 0; abus = 8'h00; dbus = 8'h00;
        while (busy && cyc < 40) begin
            if (!wr_n) wr_lo++;
            if (!rd_n) rd_lo++;
            if (!wr_n && !ad) abus = bus_out;
            if (!wr_n && ad) dbus = bus_out;
            if (done) begin
                done_at = cyc;
                ndone++;
            end
            step();
            cyc++;
        end
        check($sformatf("vec%0d_idle", n), busy, 0);
        check($sformatf("vec%0d_wr_lo", n), wr_lo, v.exp_wr_lo);
        check($sformatf("vec%0d_rd_lo", n), rd_lo, v.exp_rd_lo);
        check($sformatf("vec%0d_abus", n), abus, v.exp_abus);
        if (v.exp_wr_lo == 10) check($sformatf("vec%0d_dbus", n), dbus, v.exp_dbus);
        check($sformatf("vec%0d_done_at", n), done_at, 23);
        check($sformatf("vec%0d_ndone", n), ndone, 1);
        check($sformatf("vec%0d_rdata", n), rdata, v.exp_rdata);
    endtask

    // Runs n cycles recording each new grant; init drops its request once granted.
    task automatic collect(input int ncyc, input int drop_after);
        logic [3:0] prev;
        gq.delete();
        nd = 0;
        prev = 4'b0000;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (grant != 4'b0000 && prev == 4'b0000) begin
                gq.push_back(grant);
                if (grant[0]) req[0] = 1'b0;
                if (gq.size() >= drop_after) req = 4'b0000;
            end
            if (done) nd++;
            prev = grant;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0010, 4'b1100, 8'hEE, 4'b0010, 8'h21, 8'h45, 8'h00, 10, 0};
        vecs[1] = '{4'b1000, 4'b1100, 8'h59, 4'b1000, 8'h23, 8'h00, 8'h59, 5, 5};
        vecs[2] = '{4'b0001, 4'b1100, 8'hEE, 4'b0001, 8'h0A, 8'h3C, 8'h59, 10, 0};
        vecs[3] = '{4'b0100, 4'b1100, 8'hA5, 4'b0100, 8'h7F, 8'h00, 8'hA5, 5, 5};
        vecs[4] = '{4'b0101, 4'b1100, 8'hEE, 4'b0001, 8'h0A, 8'h3C, 8'hA5, 10, 0};
        vecs[5] = '{4'b1010, 4'b1100, 8'h66, 4'b1000, 8'h23, 8'h00, 8'h66, 5, 5};
        vecs[6] = '{4'b0110, 4'b0000, 8'hEE, 4'b0010, 8'h21, 8'h45, 8'h66, 10, 0};

        reset = 1'b1; req = 4'b0000; rnw_in = 4'b0000;
        addr_in = 32'h0; wdata_in = 32'h0; bus_in = 8'h00;
        model_reset();
        step();
        step();
        check("reset_bus_out", bus_out, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        step();
        step();

        // Asynchronous reset in the middle of a write data strobe.
        addr_in = 32'h237F210A; wdata_in = 32'h9988453C; rnw_in = 4'b1100;
        req = 4'b0010;
        step();
        req = 4'b0000;
        while (m_busy && m_t < 17) step();
        check("pre_reset_wr_n", wr_n, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("async_bus_out", bus_out, 8'h00);
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
        step();

        // Directed single transactions from the vector table.
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Init and write requested together: init first, then write.
        do_reset();
        rnw_in = 4'b0000; req = 4'b0011;
        collect(60, 2);
        check("pri_ngrants", gq.size(), 2);
        if (gq.size() == 2) begin
            check("pri_first", gq[0], 4'b0001);
            check("pri_second", gq[1], 4'b0010);
        end
        check("pri_ndone", nd, 2);

        // All round-robin requesters held: 0010, 0100, 1000, 0010.
        do_reset();
        rnw_in = 4'b1010; req = 4'b1110;
        collect(120, 4);
        check("rr_ngrants", gq.size(), 4);
        if (gq.size() == 4) begin
            check("rr_g0", gq[0], 4'b0010);
            check("rr_g1", gq[1], 4'b0100);
            check("rr_g2", gq[2], 4'b1000);
            check("rr_g3", gq[3], 4'b0010);
        end
        check("rr_ndone", nd, 4);

        // Request dropped and inputs changed right after the grant.
        addr_in = 32'h237F210A; wdata_in = 32'h9988453C; rnw_in = 4'b0000;
        req = 4'b0100;
        step();
        req = 4'b0000; addr_in = 32'hDEADBEEF; wdata_in = 32'h01020304; rnw_in = 4'b1111;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 5) check("cap_addr", bus_out, 8'h7F);
            if (c == 17) begin
                check("cap_wdata", bus_out, 8'h88);
                check("cap_wr_n", wr_n, 0);
            end
        end
        check("cap_idle", busy, 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req      = 4'($urandom) & 4'($urandom);
                rnw_in   = 4'($urandom);
                addr_in  = $urandom;
                wdata_in = $urandom;
            end
            bus_in = 8'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_bus_scheduler.md
Name: rtc_bus_scheduler

Overview:
- Owns the RTC's multiplexed address/data bus (ChipSelect, Read, Write, AoD).
- Shares the bus between four requesters: init machine, write machine, chrono machine and read machine.
- Arbitrates among them, then runs the complete two-phase bus cycle itself: an address phase, then a data phase for either a write or a read.
- Replaces level-decoded mode selection with a registered grant/done handshake; the top level only gates the tri-state buffer from bus_oe.

Parameters:
- T_SETUP, 2, cycles cs_n is low before a strobe asserts (minimum 1).
- T_STROBE, 5, cycles rd_n/wr_n stays low (minimum 1).
- T_HOLD, 2, cycles cs_n and bus stay valid after the strobe releases (minimum 1).
- T_GAP, 4, idle cycles between the address and data phases, and recovery after a transaction (minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  per-requester level request: [0] init, [1] write, [2] chrono, [3] read.
- rnw_in  in  4  per-requester access type: 1 = read, 0 = write.
- addr_in  in  32  per-requester RTC register address; requester i uses bits [8i+7:8i].
- wdata_in  in  32  per-requester write data; same packing as addr_in.
- grant  out  4  one-hot grant, held for the whole transaction.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the granted transaction completes.
- rdata  out  8  read result; valid from done until the next read completes.
- bus_in  in  8  sampled RTC data bus.
- bus_out  out  8  driven bus value.
- bus_oe  out  1  tri-state enable for bus_out.
- cs_n  out  1  RTC ChipSelect, active low.
- rd_n  out  1  RTC Read strobe, active low.
- wr_n  out  1  RTC Write strobe, active low.
- ad  out  1  AoD: 0 = address phase, 1 = data phase.

Behaviour:
- Reset values (applied immediately and asynchronously on reset):
  - cs_n = rd_n = wr_n = ad = 1.
  - bus_oe = 0; bus_out, rdata, grant = 0.
  - done = busy = 0.
  - state = IDLE; round-robin pointer = 3.
- Arbitration (evaluated in IDLE only):
  - req[0] has absolute priority.
  - req[3:1] are served round-robin, starting from the index after the pointer.
  - The pointer updates to the granted index only when the grant is for requester 1–3.
- Capture: grant, address, data and rnw of the winner are registered on the edge leaving IDLE. Later changes to the requester's inputs, or dropping req, do not abort or alter the transaction.
- States, each lasting N cycles via a down-counter:
  - IDLE.
  - A_SETUP (T_SETUP): cs_n=0, ad=0, bus_oe=1, bus_out=addr.
  - A_STROBE (T_STROBE): as A_SETUP, plus wr_n=0.
  - A_HOLD (T_HOLD): wr_n=1, all else unchanged.
  - GAP (T_GAP): cs_n=1, bus_oe=0, ad=1.
  - D_SETUP (T_SETUP): cs_n=0, ad=1.
    - Write: bus_oe=1, bus_out=wdata.
    - Read: bus_oe=0.
  - D_STROBE (T_STROBE): write drives wr_n=0; read drives rd_n=0. rdata captures bus_in on the last D_STROBE cycle.
  - D_HOLD (T_HOLD): strobes high, cs_n still 0.
  - RECOV (T_GAP): cs_n=1, bus_oe=0.
    - done=1 on the first RECOV cycle; grant cleared on entry.
    - Returns to IDLE afterwards.
- Latency (defaults):
  - Requests sampled in IDLE at edge k → grant visible after edge k.
  - done high for the cycle following edge k+23.
  - Back to IDLE after edge k+27; next grant after edge k+28 at the earliest.
- rd_n and wr_n are never low at the same time. A strobe is never low while cs_n is high.
- If req[0] asserts while a transaction is busy, it waits; the current transaction is never preempted.
- If no req is set in IDLE, the block stays idle and all outputs keep their reset values.
- All outputs are registered and glitch-free.

Decomposition:
- Package rtc_bus_pkg holds:
  - state encoding;
  - requester indices REQ_INIT=0, REQ_WRITE=1, REQ_CRONO=2, REQ_READ=3;
  - default timing constants.
- One sub-module, rtc_rr_arbiter: combinational fixed-priority plus round-robin select (inputs req and pointer; outputs one-hot winner and winner index).
- Pointer register, phase counter and FSM stay in rtc_bus_scheduler.

Test Plan:
1. Reset mid-D_STROBE during a write → wr_n, cs_n return to 1, bus_oe to 0, and grant to 0 without waiting for a clock edge; after reset is released, state is IDLE and busy=0.
2. Single write: req[1]=1, rnw_in[1]=0, addr=0x21, wdata=0x45 → address phase shows ad=0, bus_out=0x21 with wr_n low for 5 cycles; data phase shows ad=1, bus_out=0x45 with wr_n low for 5 cycles; done pulses once, 23 cycles after grant.
3. Single read: req[3]=1, rnw_in[3]=1, addr=0x23, bus_in=0x59 → rd_n low for 5 cycles, wr_n stays high during the data phase, bus_oe=0 in the data phase; rdata=0x59 at done.
4. req[0] and req[1] asserted in the same cycle → grant=0001 first, grant=0010 next; exactly two done pulses.
5. req[3:1] held continuously → grant sequence 0010, 0100, 1000, 0010, with the pointer wrapping correctly.
6. Requester drops req and changes addr_in mid-transaction → the transaction completes with the originally captured values.
